// File: rtl/isa_fetch_server.sv
// isa_fetch_server
//    Memory-side responder for the instruction-fetch read channel. A block
//    read request from the instruction cache is split into bursts of at most
//    MAX_BURST beats on the memory read port. Every delivered beat becomes one
//    instruction word, with a running word count and a one-cycle strobe.
//
// Ports
//    clk, rst                    clock, asynchronous active-low reset
//    ISA_read_req/addr/isa_read_len  cache request (level), start address, word count
//    instruction_to_cache        current instruction word
//    rd_cnt_isa                  words delivered in the current request
//    rd_burst_data_valid         one-cycle strobe per delivered word
//    isa_srv_busy                high whenever the FSM is not idle
//    mem_rd_req/addr/len         burst request to the memory controller
//    mem_rd_ack                  one-cycle acceptance of mem_rd_req
//    mem_rd_data/_valid          returned memory beat
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | waiting for a cache request
// S_ISSUE | burst request posted, waiting for mem_rd_ack
// S_XFER  | forwarding beats of the current burst to the cache
// S_DRAIN | request withdrawn; swallowing the beats still owed by memory
// S_DONE  | all words delivered; waiting for the cache to drop its request
module isa_fetch_server #(
   parameter int ISA_WIDTH      = 30,
   parameter int DDR_ADDR_WIDTH = 28,
   parameter int MEM_DATA_WIDTH = 64,
   parameter int MAX_BURST      = 64,
   parameter int ADDR_STRIDE    = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      ISA_read_req,
   input  logic [DDR_ADDR_WIDTH-1:0] ISA_read_addr,
   input  logic [9:0]                isa_read_len,
   output logic [ISA_WIDTH-1:0]      instruction_to_cache,
   output logic [9:0]                rd_cnt_isa,
   output logic                      rd_burst_data_valid,
   output logic                      isa_srv_busy,
   output logic                      mem_rd_req,
   output logic [DDR_ADDR_WIDTH-1:0] mem_rd_addr,
   output logic [9:0]                mem_rd_len,
   input  logic                      mem_rd_ack,
   input  logic [MEM_DATA_WIDTH-1:0] mem_rd_data,
   input  logic                      mem_rd_data_valid
);

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_XFER, S_DRAIN, S_DONE} state_t;

   localparam logic [9:0]                MAX_LEN = 10'(MAX_BURST);
   localparam logic [DDR_ADDR_WIDTH-1:0] STRIDE  = DDR_ADDR_WIDTH'(ADDR_STRIDE);

   state_t                    state_q, state_d;
   logic [9:0]                remaining_q, remaining_d;
   logic [9:0]                beat_cnt_q, beat_cnt_d;
   logic [9:0]                rd_cnt_q, rd_cnt_d;
   logic [9:0]                mem_len_q, mem_len_d;
   logic [DDR_ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
   logic [DDR_ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [DDR_ADDR_WIDTH-1:0] next_addr;
   logic [ISA_WIDTH-1:0]      instr_q, instr_d;
   logic                      valid_q, valid_d;
   logic                      req_q, req_d;
   logic                      busy_q;
   logic                      unused_data;

   // Only the low ISA_WIDTH bits of a beat are forwarded.
   assign unused_data = ^mem_rd_data;

   function automatic logic [9:0] burst_len(input logic [9:0] n);
      return (n > MAX_LEN) ? MAX_LEN : n;
   endfunction

   // mem_len_q still holds the length of the burst being received.
   assign next_addr = cur_addr_q + DDR_ADDR_WIDTH'(mem_len_q) * STRIDE;

   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      beat_cnt_d  = beat_cnt_q;
      rd_cnt_d    = rd_cnt_q;
      mem_len_d   = mem_len_q;
      cur_addr_d  = cur_addr_q;
      mem_addr_d  = mem_addr_q;
      instr_d     = instr_q;
      valid_d     = 1'b0;
      req_d       = req_q;
      unique case (state_q)
         S_IDLE: begin
            if (ISA_read_req) begin
               cur_addr_d  = ISA_read_addr;
               remaining_d = isa_read_len;
               rd_cnt_d    = '0;
               if (isa_read_len == '0) begin
                  state_d = S_DONE;
               end else begin
                  state_d    = S_ISSUE;
                  req_d      = 1'b1;
                  mem_addr_d = ISA_read_addr;
                  mem_len_d  = burst_len(isa_read_len);
               end
            end
         end
         S_ISSUE: begin
            // A beat coinciding with the ack is ignored: memory must not
            // return data before acknowledging the burst.
            if (req_q && mem_rd_ack) begin
               req_d      = 1'b0;
               beat_cnt_d = mem_len_q;
               state_d    = ISA_read_req ? S_XFER : S_DRAIN;
            end
         end
         S_XFER: begin
            if (mem_rd_data_valid) begin
               instr_d     = mem_rd_data[ISA_WIDTH-1:0];
               valid_d     = 1'b1;
               rd_cnt_d    = rd_cnt_q + 10'd1;
               remaining_d = remaining_q - 10'd1;
               beat_cnt_d  = beat_cnt_q - 10'd1;
               if (beat_cnt_q == 10'd1) begin
                  if (remaining_q == 10'd1) begin
                     state_d = S_DONE;
                  end else if (ISA_read_req) begin
                     cur_addr_d = next_addr;
                     mem_addr_d = next_addr;
                     mem_len_d  = burst_len(remaining_q - 10'd1);
                     req_d      = 1'b1;
                     state_d    = S_ISSUE;
                  end else begin
                     state_d = S_DRAIN;
                  end
               end else if (!ISA_read_req) begin
                  state_d = S_DRAIN;
               end
            end else if (!ISA_read_req) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (beat_cnt_q == '0) begin
               state_d  = S_IDLE;
               rd_cnt_d = '0;
            end else if (mem_rd_data_valid) begin
               beat_cnt_d = beat_cnt_q - 10'd1;
            end
         end
         S_DONE: begin
            if (!ISA_read_req) begin
               state_d  = S_IDLE;
               rd_cnt_d = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         remaining_q <= '0;
         beat_cnt_q  <= '0;
         rd_cnt_q    <= '0;
         mem_len_q   <= '0;
         cur_addr_q  <= '0;
         mem_addr_q  <= '0;
         instr_q     <= '0;
         valid_q     <= 1'b0;
         req_q       <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         beat_cnt_q  <= beat_cnt_d;
         rd_cnt_q    <= rd_cnt_d;
         mem_len_q   <= mem_len_d;
         cur_addr_q  <= cur_addr_d;
         mem_addr_q  <= mem_addr_d;
         instr_q     <= instr_d;
         valid_q     <= valid_d;
         req_q       <= req_d;
         busy_q      <= (state_d != S_IDLE);
      end
   end

   assign instruction_to_cache = instr_q;
   assign rd_cnt_isa           = rd_cnt_q;
   assign rd_burst_data_valid  = valid_q;
   assign isa_srv_busy         = busy_q;
   assign mem_rd_req           = req_q;
   assign mem_rd_addr          = mem_addr_q;
   assign mem_rd_len           = mem_len_q;

endmodule

// File: tb/tb_isa_fetch_server.sv
module tb_isa_fetch_server;
   localparam int AW = 28;
   localparam int DW = 64;
   localparam int IW = 30;

   logic          clk = 1'b0;
   logic          rst;
   logic          ISA_read_req;
   logic [AW-1:0] ISA_read_addr;
   logic [9:0]    isa_read_len;
   logic [IW-1:0] instruction_to_cache;
   logic [9:0]    rd_cnt_isa;
   logic          rd_burst_data_valid;
   logic          isa_srv_busy;
   logic          mem_rd_req;
   logic [AW-1:0] mem_rd_addr;
   logic [9:0]    mem_rd_len;
   logic          mem_rd_ack;
   logic [DW-1:0] mem_rd_data;
   logic          mem_rd_data_valid;

   always #5 clk = ~clk;

   isa_fetch_server dut (
      .clk                  (clk),
      .rst                  (rst),
      .ISA_read_req         (ISA_read_req),
      .ISA_read_addr        (ISA_read_addr),
      .isa_read_len         (isa_read_len),
      .instruction_to_cache (instruction_to_cache),
      .rd_cnt_isa           (rd_cnt_isa),
      .rd_burst_data_valid  (rd_burst_data_valid),
      .isa_srv_busy         (isa_srv_busy),
      .mem_rd_req           (mem_rd_req),
      .mem_rd_addr          (mem_rd_addr),
      .mem_rd_len           (mem_rd_len),
      .mem_rd_ack           (mem_rd_ack),
      .mem_rd_data          (mem_rd_data),
      .mem_rd_data_valid    (mem_rd_data_valid)
   );

   typedef struct packed { logic [9:0] cnt; logic [IW-1:0] data; } beat_t;
   typedef struct packed { logic [AW-1:0] addr; logic [9:0] len; } burst_t;
   typedef struct {
      logic [AW-1:0] addr;
      logic [9:0]    len;
      int            gap_mode;    // 0 back-to-back, 1 every third cycle idle, 2 random gaps
      int            data_mode;   // 0 data = word number, 1 all ones, 2 random
      int            ack_delay;
      int            exp_nbursts;
   } vec_t;

   beat_t         exp_beats[$];
   burst_t        exp_bursts[$];
   vec_t          vecs[9];

   int            checks = 0;
   int            errors = 0;
   int            beats_left = 0;
   int            ack_cnt = 0;
   int            beat_idx = 0;
   int            acks = 0;
   int            strobes = 0;
   int            cyc = 0;
   int            gap_mode = 0;
   int            data_mode = 0;
   int            ack_delay = 0;
   bit            draining = 1'b0;
   bit            mem_pause = 1'b0;
   logic [IW-1:0] last_data = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic monitor();
      beat_t b;
      if (rd_burst_data_valid) begin
         strobes++;
         if (exp_beats.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_strobe: got cnt %0d data 0x%0h, expected no strobe",
                     rd_cnt_isa, instruction_to_cache);
         end else begin
            b = exp_beats.pop_front();
            chk("strobe_cnt", 64'(rd_cnt_isa), 64'(b.cnt));
            chk("strobe_data", 64'(instruction_to_cache), 64'(b.data));
         end
      end
   endtask

   // Memory controller model; drives its inputs for the next edge.
   task automatic mem_drive();
      burst_t        bu;
      logic [DW-1:0] d;
      bit            gap;
      cyc++;
      mem_rd_ack        = 1'b0;
      mem_rd_data_valid = 1'b0;
      // request low at the edge just passed with beats owed: server drains
      if (beats_left > 0 && !ISA_read_req) draining = 1'b1;
      if (beats_left > 0) begin
         case (gap_mode)
            1:       gap = (cyc % 3 == 0);
            2:       gap = ($urandom_range(0, 3) == 0);
            default: gap = 1'b0;
         endcase
         if (!gap && !mem_pause) begin
            case (data_mode)
               1:       d = '1;
               2:       d = {$urandom, $urandom};
               default: d = DW'(beat_idx + 1);
            endcase
            mem_rd_data       = d;
            mem_rd_data_valid = 1'b1;
            beats_left--;
            if (!draining) begin
               beat_idx++;
               last_data = d[IW-1:0];
               exp_beats.push_back('{cnt: 10'(beat_idx), data: d[IW-1:0]});
            end
         end
      end else if (mem_rd_req) begin
         if (ack_cnt >= ack_delay) begin
            mem_rd_ack = 1'b1;
            ack_cnt    = 0;
            acks++;
            beats_left = int'(mem_rd_len);
            if (exp_bursts.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_burst: got addr 0x%0h len %0d, expected none",
                        mem_rd_addr, mem_rd_len);
            end else begin
               bu = exp_bursts.pop_front();
               chk("burst_addr", 64'(mem_rd_addr), 64'(bu.addr));
               chk("burst_len", 64'(mem_rd_len), 64'(bu.len));
            end
         end else begin
            ack_cnt++;
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      monitor();
      mem_drive();
   endtask

   task automatic setup_req(input vec_t v);
      logic [AW-1:0] a;
      int            rem;
      int            l;
      gap_mode  = v.gap_mode;
      data_mode = v.data_mode;
      ack_delay = v.ack_delay;
      draining  = 1'b0;
      beat_idx  = 0;
      acks      = 0;
      ack_cnt   = 0;
      strobes   = 0;
      a   = v.addr;
      rem = int'(v.len);
      while (rem > 0) begin
         l = (rem > 64) ? 64 : rem;
         exp_bursts.push_back('{addr: a, len: 10'(l)});
         a   = a + AW'(l * 8);
         rem = rem - l;
      end
      ISA_read_req  = 1'b1;
      ISA_read_addr = v.addr;
      isa_read_len  = v.len;
      step();
      chk("accept_busy", 64'(isa_srv_busy), 64'd1);
      chk("accept_req", 64'(mem_rd_req), 64'(v.len != 10'd0));
      chk("accept_cnt", 64'(rd_cnt_isa), 64'd0);
      // ignored after acceptance
      ISA_read_addr = AW'($urandom);
      isa_read_len  = 10'($urandom);
   endtask

   task automatic run_vec(input vec_t v);
      int guard = 0;
      setup_req(v);
      while (!(beat_idx == int'(v.len) && exp_beats.size() == 0 && beats_left == 0)
             && guard < 3000) begin
         step();
         guard++;
      end
      if (guard >= 3000) begin
         checks++;
         errors++;
         $display("FAIL timeout: got %0d words, expected %0d", beat_idx, v.len);
      end
      chk("final_cnt", 64'(rd_cnt_isa), 64'(v.len));
      chk("done_busy", 64'(isa_srv_busy), 64'd1);
      chk("done_no_req", 64'(mem_rd_req), 64'd0);
      chk("burst_count", 64'(acks), 64'(v.exp_nbursts));
      ISA_read_req = 1'b0;
      step();
      chk("idle_cnt", 64'(rd_cnt_isa), 64'd0);
      chk("idle_busy", 64'(isa_srv_busy), 64'd0);
      if (v.len != 10'd0) chk("instr_hold", 64'(instruction_to_cache), 64'(last_data));
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_instr"}, 64'(instruction_to_cache), 64'd0);
      chk({tag, "_cnt"}, 64'(rd_cnt_isa), 64'd0);
      chk({tag, "_strobe"}, 64'(rd_burst_data_valid), 64'd0);
      chk({tag, "_busy"}, 64'(isa_srv_busy), 64'd0);
      chk({tag, "_req"}, 64'(mem_rd_req), 64'd0);
      chk({tag, "_addr"}, 64'(mem_rd_addr), 64'd0);
      chk({tag, "_len"}, 64'(mem_rd_len), 64'd0);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int   guard;
      vec_t v;
      vecs[0] = '{28'h0000080,  10'd5,   0, 0, 2, 1};   // single burst, data 1..5
      vecs[1] = '{28'h0000000,  10'd128, 1, 2, 1, 2};   // split, gapped beats
      vecs[2] = '{28'h0000000,  10'd128, 0, 0, 0, 2};   // split, back-to-back beats
      vecs[3] = '{28'h0000123,  10'd0,   0, 0, 0, 0};   // zero length
      vecs[4] = '{28'h0000040,  10'd2,   0, 1, 0, 1};   // truncation of all-ones beats
      vecs[5] = '{28'hFFFFFF0,  10'd70,  2, 2, 3, 2};   // second burst address wraps
      vecs[6] = '{28'h0000100,  10'd64,  2, 0, 1, 1};   // exactly one max burst
      vecs[7] = '{28'h0000200,  10'd65,  0, 2, 0, 2};   // one beat over max burst
      vecs[8] = '{28'h0000010,  10'd1,   1, 2, 0, 1};   // single word

      rst = 1'b0;
      ISA_read_req = 1'b0;
      ISA_read_addr = '0;
      isa_read_len = '0;
      mem_rd_ack = 1'b0;
      mem_rd_data = '0;
      mem_rd_data_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_all_zero("reset");
      rst = 1'b1;
      step();

      for (int i = 0; i < 9; i++) begin
         run_vec(vecs[i]);
         if (i == 4) chk("trunc_value", 64'(instruction_to_cache), 64'h3FFF_FFFF);
         step();
      end

      // abort after 10 of 64 beats
      v = '{28'h0000400, 10'd64, 0, 0, 0, 1};
      setup_req(v);
      guard = 0;
      while (beat_idx < 10 && guard < 500) begin step(); guard++; end
      mem_pause = 1'b1;
      repeat (3) step();
      chk("abort_strobes", 64'(strobes), 64'd10);
      chk("abort_cnt_before", 64'(rd_cnt_isa), 64'd10);
      ISA_read_req = 1'b0;
      step();
      mem_pause = 1'b0;
      guard = 0;
      while (beats_left > 0 && guard < 500) begin step(); guard++; end
      if (guard >= 500) begin
         checks++;
         errors++;
         $display("FAIL abort_drain_timeout: got %0d beats left, expected 0", beats_left);
      end
      repeat (3) step();
      chk("abort_strobes_after", 64'(strobes), 64'd10);
      chk("abort_cnt", 64'(rd_cnt_isa), 64'd0);
      chk("abort_busy", 64'(isa_srv_busy), 64'd0);
      chk("abort_no_req", 64'(mem_rd_req), 64'd0);
      chk("abort_bursts", 64'(acks), 64'd1);
      run_vec('{28'h0000800, 10'd3, 0, 0, 0, 1});
      step();

      // reset in the middle of a transfer
      v = '{28'h0000300, 10'd40, 0, 0, 0, 1};
      setup_req(v);
      guard = 0;
      while (beat_idx < 5 && guard < 500) begin step(); guard++; end
      rst = 1'b0;
      #1;
      chk_all_zero("midrst");
      exp_beats.delete();
      exp_bursts.delete();
      draining = 1'b1;
      ISA_read_req = 1'b0;
      repeat (2) step();
      rst = 1'b1;
      guard = 0;
      while (beats_left > 0 && guard < 500) begin step(); guard++; end
      repeat (2) step();
      chk("postrst_cnt", 64'(rd_cnt_isa), 64'd0);
      chk("postrst_busy", 64'(isa_srv_busy), 64'd0);
      chk("postrst_strobe", 64'(rd_burst_data_valid), 64'd0);
      chk("postrst_no_req", 64'(mem_rd_req), 64'd0);
      run_vec('{28'h0000900, 10'd4, 1, 0, 1, 1});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
